// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: keypad matrix lines plus the decoded key outputs.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
   logic [3:0] col;
   logic [3:0] row;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;

   modport master (input col, output row, output key_code, output key_valid, output key_down);
   modport slave  (output col, input row, input key_code, input key_valid, input key_down);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with tick-based debounce of press and release.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_SCANNER_REPEAT_EN.
module keypad_scanner #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 4,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10
) (
   input  logic               clock,
   input  logic               reset,
   keypad_scanner_if.master   kp
);

   typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED} state_t;

   localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
   localparam logic [3:0]  CNT_LAST = 4'(DEBOUNCE_CNT - 1);

   state_t      state_reg, state_next;
   logic [15:0] div_reg;
   logic        tick;
   logic [3:0]  col_meta_reg, col_sync_reg;
   logic [1:0]  ridx_reg, ridx_next;
   logic [1:0]  cidx_reg, cidx_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [3:0]  key_code_reg;
   logic        key_valid_reg;
   logic        hit;
   logic [1:0]  hit_col;
   logic        same_col;
   logic        accept;
   logic        repeat_fire;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         col_meta_reg <= 4'b1111;
         col_sync_reg <= 4'b1111;
         div_reg      <= 16'd0;
      end else begin
         col_meta_reg <= kp.col;
         col_sync_reg <= col_meta_reg;
         div_reg      <= (div_reg == DIV_LAST) ? 16'd0 : div_reg + 16'd1;
      end
   end

   assign tick = (div_reg == DIV_LAST);

   // Only a single low column is a usable key; ghosting/multi-press is ignored.
   always_comb begin
      hit     = 1'b0;
      hit_col = 2'd0;
      case (col_sync_reg)
         4'b1110: begin hit = 1'b1; hit_col = 2'd0; end
         4'b1101: begin hit = 1'b1; hit_col = 2'd1; end
         4'b1011: begin hit = 1'b1; hit_col = 2'd2; end
         4'b0111: begin hit = 1'b1; hit_col = 2'd3; end
         default: ;
      endcase
   end

   assign same_col = hit && (hit_col == cidx_reg);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= S_SCAN;
         ridx_reg  <= 2'd0;
         cidx_reg  <= 2'd0;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         ridx_reg  <= ridx_next;
         cidx_reg  <= cidx_next;
         cnt_reg   <= cnt_next;
      end
   end

   // cnt_reg counts matching ticks in DEBOUNCE and consecutive release ticks in PRESSED.
   always_comb begin
      state_next = state_reg;
      ridx_next  = ridx_reg;
      cidx_next  = cidx_reg;
      cnt_next   = cnt_reg;
      if (tick) begin
         case (state_reg)
            S_SCAN: begin
               if (hit) begin
                  cidx_next  = hit_col;
                  cnt_next   = 4'd0;
                  state_next = S_DEBOUNCE;
               end else begin
                  ridx_next = ridx_reg + 2'd1;
               end
            end
            S_DEBOUNCE: begin
               if (same_col) begin
                  if (cnt_reg == CNT_LAST) begin
                     state_next = S_PRESSED;
                     cnt_next   = 4'd0;
                  end else begin
                     cnt_next = cnt_reg + 4'd1;
                  end
               end else begin
                  state_next = S_SCAN;
                  ridx_next  = ridx_reg + 2'd1;
               end
            end
            S_PRESSED: begin
               if (same_col) begin
                  cnt_next = 4'd0;
               end else if (cnt_reg == CNT_LAST) begin
                  state_next = S_SCAN;
                  ridx_next  = ridx_reg + 2'd1;
                  cnt_next   = 4'd0;
               end else begin
                  cnt_next = cnt_reg + 4'd1;
               end
            end
            default: state_next = S_SCAN;
         endcase
      end
   end

   always_comb begin
      accept      = tick && (state_reg == S_DEBOUNCE) && same_col && (cnt_reg == CNT_LAST);
      kp.key_down = (state_reg == S_PRESSED);
      kp.row      = ~(4'b0001 << ridx_reg);
   end

`ifdef KEYPAD_SCANNER_REPEAT_EN
   logic [15:0] rep_cnt_reg;
   logic        rep_first_reg;
   logic [15:0] rep_target;

   assign rep_target  = rep_first_reg ? 16'(REPEAT_DELAY) : 16'(REPEAT_RATE);
   assign repeat_fire = tick && (state_reg == S_PRESSED) && same_col
                        && ((rep_cnt_reg + 16'd1) == rep_target);

   // Any tick without the held key restarts the wait from the initial delay.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rep_cnt_reg   <= 16'd0;
         rep_first_reg <= 1'b1;
      end else if (tick) begin
         if ((state_reg != S_PRESSED) || !same_col) begin
            rep_cnt_reg   <= 16'd0;
            rep_first_reg <= 1'b1;
         end else if (repeat_fire) begin
            rep_cnt_reg   <= 16'd0;
            rep_first_reg <= 1'b0;
         end else begin
            rep_cnt_reg <= rep_cnt_reg + 16'd1;
         end
      end
   end
`else
   assign repeat_fire = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         key_code_reg  <= 4'd0;
         key_valid_reg <= 1'b0;
      end else begin
         key_valid_reg <= accept || repeat_fire;
         if (accept) begin
            key_code_reg <= {ridx_reg, cidx_reg};
         end
      end
   end

   assign kp.key_code  = key_code_reg;
   assign kp.key_valid = key_valid_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: simulated key matrix, tick-level reference model,
// a constant vector table for a full press/release, and randomized key activity.
module tb_keypad_scanner;
   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 3;
   localparam int REPEAT_DELAY = 5;
   localparam int REPEAT_RATE  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   keypad_scanner_if kp_if();

   keypad_scanner #(
      .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
   ) dut (
      .clock(clk),
      .reset(rst),
      .kp(kp_if)
   );

   int checks   = 0;
   int failures = 0;

   logic [15:0] mask;   // bit r*4+c set = key at row r, column c held

   // Tick-level reference: which phase the keypad is in, per the documented rules.
   int m_phase;         // 0 scanning, 1 confirming press, 2 key held
   int m_row, m_col, m_cnt, m_code, m_rep;
   bit m_first;

   typedef struct {
      logic [15:0] mask;
      logic [3:0]  row;
      bit          valid;
      bit          down;
      logic [3:0]  code;
   } vec_t;
   vec_t tbl[12];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_row = 0; m_col = 0; m_cnt = 0; m_code = 0; m_rep = 0; m_first = 1'b1;
   endtask

   task automatic model_tick(input logic [3:0] cv, output bit strobe);
      int lows, ci;
      bit same;
      lows = 0; ci = 0; strobe = 1'b0;
      for (int c = 0; c < 4; c++) if (!cv[c]) begin lows++; ci = c; end
      same = (lows == 1) && (ci == m_col);
      if (m_phase == 0) begin
         if (lows == 1) begin m_col = ci; m_cnt = 0; m_phase = 1; end
         else m_row = (m_row + 1) % 4;
      end else if (m_phase == 1) begin
         if (!same) begin m_phase = 0; m_row = (m_row + 1) % 4; end
         else if (m_cnt == DEBOUNCE_CNT - 1) begin
            m_phase = 2; m_cnt = 0; strobe = 1'b1; m_code = m_row * 4 + m_col;
            m_rep = 0; m_first = 1'b1;
         end else m_cnt++;
      end else begin
         if (same) begin
            m_cnt = 0;
`ifdef KEYPAD_SCANNER_REPEAT_EN
            m_rep++;
            if (m_rep == (m_first ? REPEAT_DELAY : REPEAT_RATE)) begin
               strobe = 1'b1; m_rep = 0; m_first = 1'b0;
            end
`endif
         end else begin
            m_rep = 0; m_first = 1'b1;
            if (m_cnt == DEBOUNCE_CNT - 1) begin
               m_phase = 0; m_cnt = 0; m_row = (m_row + 1) % 4;
            end else m_cnt++;
         end
      end
   endtask

   // One row dwell: drive columns from the key matrix, run SCAN_DIV clocks, check every cycle.
   task automatic dwell(output bit strobe);
      logic [3:0] cv;
      logic [3:0] er;
      bit exp_v;
      cv = 4'b1111;
      for (int c = 0; c < 4; c++) if (mask[m_row * 4 + c]) cv[c] = 1'b0;
      kp_if.col = cv;
      strobe = 1'b0;
      for (int e = 1; e <= SCAN_DIV; e++) begin
         @(posedge clk);
         exp_v = 1'b0;
         if (e == SCAN_DIV) model_tick(cv, exp_v);
         @(negedge clk);
         er = ~(4'b0001 << m_row);
         check("row", kp_if.row, er);
         check("key_valid", kp_if.key_valid, exp_v);
         check("key_down", kp_if.key_down, (m_phase == 2) ? 1 : 0);
         check("key_code", kp_if.key_code, m_code);
         if (kp_if.key_valid) strobe = 1'b1;
      end
   endtask

   initial begin
      bit s;
      int nstrobe;
      int q[$];
      logic [15:0] saved;
      bit got;

      tbl[0]  = '{16'h0200, 4'b1101, 1'b0, 1'b0, 4'd0};
      tbl[1]  = '{16'h0200, 4'b1011, 1'b0, 1'b0, 4'd0};
      tbl[2]  = '{16'h0200, 4'b1011, 1'b0, 1'b0, 4'd0};
      tbl[3]  = '{16'h0200, 4'b1011, 1'b0, 1'b0, 4'd0};
      tbl[4]  = '{16'h0200, 4'b1011, 1'b0, 1'b0, 4'd0};
      tbl[5]  = '{16'h0200, 4'b1011, 1'b1, 1'b1, 4'd9};
      tbl[6]  = '{16'h0200, 4'b1011, 1'b0, 1'b1, 4'd9};
      tbl[7]  = '{16'h0200, 4'b1011, 1'b0, 1'b1, 4'd9};
      tbl[8]  = '{16'h0000, 4'b1011, 1'b0, 1'b1, 4'd9};
      tbl[9]  = '{16'h0000, 4'b1011, 1'b0, 1'b1, 4'd9};
      tbl[10] = '{16'h0000, 4'b0111, 1'b0, 1'b0, 4'd9};
      tbl[11] = '{16'h0000, 4'b1110, 1'b0, 1'b0, 4'd9};

      mask = 16'h0000;
      kp_if.col = 4'b1111;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_row", kp_if.row, 4'b1110);
      check("reset_valid", kp_if.key_valid, 0);
      check("reset_down", kp_if.key_down, 0);
      check("reset_code", kp_if.key_code, 0);
      rst = 1'b0;

      // Full press of key 9 and its release, against hand-derived constants.
      for (int i = 0; i < 12; i++) begin
         mask = tbl[i].mask;
         dwell(s);
         check($sformatf("tbl%0d_row", i), kp_if.row, tbl[i].row);
         check($sformatf("tbl%0d_valid", i), s, tbl[i].valid);
         check($sformatf("tbl%0d_down", i), kp_if.key_down, tbl[i].down);
         check($sformatf("tbl%0d_code", i), kp_if.key_code, tbl[i].code);
      end

      // Bounce on key 0 for 10 ticks, then stable for 8 ticks.
      nstrobe = 0;
      for (int i = 0; i < 10; i++) begin
         mask = (i % 2 == 0) ? 16'h0001 : 16'h0000;
         dwell(s); nstrobe += int'(s);
      end
      check("bounce_strobes", nstrobe, 0);
      mask = 16'h0001; nstrobe = 0;
      for (int i = 0; i < 8; i++) begin dwell(s); nstrobe += int'(s); end
      check("stable_strobes", nstrobe, 1);
      check("stable_code", kp_if.key_code, 0);
      mask = 16'h0000;
      for (int i = 0; i < 4; i++) dwell(s);
      check("release_down", kp_if.key_down, 0);

      // Two columns low on row 0 is no key.
      mask = 16'h0006; nstrobe = 0;
      for (int i = 0; i < 8; i++) begin dwell(s); nstrobe += int'(s); end
      check("twocol_strobes", nstrobe, 0);
      check("twocol_down", kp_if.key_down, 0);
      mask = 16'h0000;

      // Long hold of key 6: strobe spacing depends on auto-repeat.
      mask = 16'h0040;
      for (int i = 0; i < 25; i++) begin dwell(s); if (s) q.push_back(i); end
`ifdef KEYPAD_SCANNER_REPEAT_EN
      check("repeat_count_ge3", (q.size() >= 3) ? 1 : 0, 1);
      if (q.size() >= 3) begin
         check("repeat_first_gap", q[1] - q[0], REPEAT_DELAY);
         check("repeat_next_gap", q[2] - q[1], REPEAT_RATE);
      end
`else
      check("hold_strobe_count", q.size(), 1);
`endif
      check("hold_code", kp_if.key_code, 6);
      mask = 16'h0000;
      for (int i = 0; i < 4; i++) dwell(s);

      // Reset while a key is held.
      mask = 16'h0200; got = 1'b0;
      for (int i = 0; i < 16 && !got; i++) begin dwell(s); got = kp_if.key_down; end
      check("press_before_reset", got, 1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_down", kp_if.key_down, 0);
      check("rst_mid_row", kp_if.row, 4'b1110);
      check("rst_mid_code", kp_if.key_code, 0);
      check("rst_mid_valid", kp_if.key_valid, 0);
      mask = 16'h0000; kp_if.col = 4'b1111;
      repeat (2) @(negedge clk);
      model_reset();
      rst = 1'b0;
      dwell(s);
      check("post_reset_first_tick_row", kp_if.row, 4'b1101);

      // Randomized key activity against the reference model.
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 3))
               0:       mask = 16'h0000;
               3:       mask = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
               default: mask = 16'h0001 << $urandom_range(0, 15);
            endcase
         end
         saved = mask;
         if ($urandom_range(0, 9) == 0) mask = 16'h0000;
         dwell(s);
         mask = saved;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
